window_player: RTL

- Playback-side counterpart of the capture path.
- Reads one processed window of 16-bit samples from the output ring buffer, starting at the window selected by window_start.
- Streams each sample to the Wolfson codec's left and right Avalon-ST sinks (same sample on both channels).
- Sits between the last processing stage (which pulses go_in) and the audio CODEC core.

---
 rtl/window_player_pkg.sv | 16 +
 rtl/window_player_stereo_st_out.sv | 44 ++++
 rtl/window_player.sv | 131 +++++++++++++
 3 files changed

// File: rtl/window_player_pkg.sv
// Shared types for the window playback path.
package player_pkg;

   localparam int NUM_WINDOWS = 4;
   localparam int SAMPLE_W    = 16;

   typedef logic [SAMPLE_W-1:0] sample_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      WAIT    = 2'd2,
      PRESENT = 2'd3
   } state_e;

endpackage

// File: rtl/window_player_stereo_st_out.sv
// Stereo Avalon-ST source: one sample presented to both channels, each channel
// drops valid after its own transfer; both_done marks the cycle the pair completes.
module stereo_st_out #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              left_ready,
   input  logic              right_ready,
   output logic [DATA_W-1:0] left_data,
   output logic              left_valid,
   output logic [DATA_W-1:0] right_data,
   output logic              right_valid,
   output logic              both_done
);

   logic [DATA_W-1:0] data_q;

   // Done once every still-pending channel is transferring this cycle.
   assign both_done = (left_valid || right_valid) &&
                      (!left_valid  || left_ready) &&
                      (!right_valid || right_ready);

   assign left_data  = data_q;
   assign right_data = data_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q      <= '0;
         left_valid  <= 1'b0;
         right_valid <= 1'b0;
      end else if (load) begin
         data_q      <= load_data;
         left_valid  <= 1'b1;
         right_valid <= 1'b1;
      end else begin
         if (left_valid && left_ready)   left_valid  <= 1'b0;
         if (right_valid && right_ready) right_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/window_player.sv
// Plays one window of ring-buffer samples to the codec's stereo sinks.
// Optional zero-fill on underrun: define WINDOW_PLAYER_UNDERRUN_ZERO_EN.
module window_player
   import player_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 13,
   parameter int WINDOW_LEN = 2048
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           go_in,
   input  logic [$clog2(NUM_WINDOWS)-1:0] window_start,
   output logic [ADDR_W-1:0]              ring_buf_addr,
   output logic                           ring_buf_rden,
   input  logic [DATA_W-1:0]              ring_buf_q,
   output logic [DATA_W-1:0]              left_out_data,
   output logic                           left_out_valid,
   input  logic                           left_out_ready,
   output logic [DATA_W-1:0]              right_out_data,
   output logic                           right_out_valid,
   input  logic                           right_out_ready,
   output logic                           busy,
   output logic                           go_out
`ifdef WINDOW_PLAYER_UNDERRUN_ZERO_EN
   , output logic [15:0]                  underrun_count
`endif
);

   localparam int                WS_W     = $clog2(NUM_WINDOWS);
   localparam int                OFF_W    = $clog2(WINDOW_LEN);
   localparam logic [OFF_W-1:0]  LAST_OFF = OFF_W'(WINDOW_LEN - 1);

   function automatic logic [ADDR_W-1:0] win_base(input logic [WS_W-1:0] w);
      return ADDR_W'(w) << OFF_W;
   endfunction

   state_e             state;
   logic [ADDR_W-1:0]  base;
   logic [OFF_W-1:0]   offset;
   logic               pend_vld;
   logic [WS_W-1:0]    pend_win;

   logic               both_done, load, idle_free, start, sample_done, last;
   logic               pend_now_vld;
   logic [WS_W-1:0]    pend_now_win;
   logic [DATA_W-1:0]  load_data;

   // A go_in this cycle counts as pending and, being newest, wins the slot.
   assign pend_now_vld = pend_vld || go_in;
   assign pend_now_win = go_in ? window_start : pend_win;

   assign last        = (offset == LAST_OFF);
   assign sample_done = (state == PRESENT) && both_done;
   assign start       = (state == IDLE && idle_free && pend_now_vld) ||
                        (sample_done && last && pend_now_vld);

   assign go_out        = sample_done && last;
   assign busy          = (state != IDLE);
   assign ring_buf_rden = (state == FETCH);
   assign ring_buf_addr = ring_buf_rden ? base + ADDR_W'(offset) : '0;

`ifdef WINDOW_PLAYER_UNDERRUN_ZERO_EN
   logic zero_load;

   // A zero sample in flight must finish before a new window may fetch.
   assign idle_free = !(left_out_valid || right_out_valid) || both_done;
   assign zero_load = (state == IDLE) && idle_free && !pend_now_vld;
   assign load      = (state == WAIT) || zero_load;
   assign load_data = (state == WAIT) ? ring_buf_q : '0;

   always_ff @(posedge clk) begin
      if (reset)
         underrun_count <= '0;
      else if (state == IDLE && both_done && underrun_count != 16'hFFFF)
         underrun_count <= underrun_count + 16'd1;
   end
`else
   assign idle_free = 1'b1;
   assign load      = (state == WAIT);
   assign load_data = ring_buf_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         base     <= '0;
         offset   <= '0;
         pend_vld <= 1'b0;
         pend_win <= '0;
      end else if (start) begin
         base     <= win_base(pend_now_win);
         offset   <= '0;
         pend_vld <= 1'b0;
         state    <= FETCH;
      end else begin
         if (go_in) begin
            pend_vld <= 1'b1;
            pend_win <= window_start;
         end
         case (state)
            FETCH:   state <= WAIT;
            WAIT:    state <= PRESENT;
            PRESENT: if (both_done) begin
               if (last) begin
                  state <= IDLE;
               end else begin
                  offset <= offset + OFF_W'(1);
                  state  <= FETCH;
               end
            end
            default: ;
         endcase
      end
   end

   stereo_st_out #(.DATA_W(DATA_W)) u_out (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .load_data   (load_data),
      .left_ready  (left_out_ready),
      .right_ready (right_out_ready),
      .left_data   (left_out_data),
      .left_valid  (left_out_valid),
      .right_data  (right_out_data),
      .right_valid (right_out_valid),
      .both_done   (both_done)
   );

endmodule
